// File: rtl/md_pkg.sv
// Shared constants, FSM state type and byte-placement helper for the
// Merkle-Damgard block padder.
package md_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned BLOCK_BITS  = 512;
    localparam int unsigned LEN_OFFSET  = 56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EXTRA,
        EMIT
    } state_t;

    // Bit offset of message byte idx within a block: MD5 packs from the LSB,
    // SHA packs from the MSB.
    function automatic logic [8:0] byte_offset(input logic [5:0] idx, input logic big_endian);
        return big_endian ? 9'(9'd504 - {idx, 3'b000}) : {idx, 3'b000};
    endfunction

endpackage

// File: rtl/md_block_padder_if.sv
// Byte-stream input and block output channels of the padder, each with
// a valid/ready handshake.
interface md_block_padder_if #(
    parameter int unsigned IN_BYTES = 1
);
    logic                          big_endian;
    logic                          in_valid;
    logic                          in_ready;
    logic [8*IN_BYTES-1:0]         in_data;
    logic                          in_last;
    logic [$clog2(IN_BYTES):0]     in_nbytes;

    logic                          blk_valid;
    logic                          blk_ready;
    logic [511:0]                  blk_data;
    logic                          blk_first;
    logic                          blk_final;

    modport master (
        output big_endian, in_valid, in_data, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_final
    );

    modport slave (
        input  big_endian, in_valid, in_data, in_last, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_final
    );
endinterface

// File: rtl/md_lane_insert.sv
// Places the valid bytes of one input beat at message positions ptr..ptr+n-1,
// producing per-byte-lane write enables and the lane-aligned write data.
module md_lane_insert
    import md_pkg::*;
#(
    parameter int unsigned IN_BYTES = 1
) (
    input  logic [6:0]              ptr,
    input  logic [6:0]              n,
    input  logic [8*IN_BYTES-1:0]   beat,
    input  logic                    big_endian,
    output logic [63:0]             en,
    output logic [511:0]            lanes
);

    logic [6:0] idx;
    logic [8:0] off;
    logic [7:0] byte_v;

    always_comb begin
        en     = '0;
        lanes  = '0;
        idx    = '0;
        off    = '0;
        byte_v = '0;
        for (int unsigned k = 0; k < IN_BYTES; k++) begin
            idx    = ptr + 7'(k);
            byte_v = 8'(beat >> (8 * k));
            if (7'(k) < n && idx < 7'(BLOCK_BYTES)) begin
                off              = byte_offset(idx[5:0], big_endian);
                en[off[8:3]]     = 1'b1;
                lanes[off +: 8]  = byte_v;
            end
        end
    end

endmodule

// File: rtl/md_block_padder.sv
// Packs a byte stream into 512-bit blocks with Merkle-Damgard padding and
// a bit-length trailer, in MD5 or SHA byte order.
module md_block_padder
    import md_pkg::*;
#(
    parameter int unsigned IN_BYTES = 1,
    parameter int unsigned LEN_BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    output logic            busy,
    md_block_padder_if.slave bus
);

    state_t                 state;
    state_t                 after_emit;
    logic [6:0]             ptr;
    logic [6:0]             n;
    logic [6:0]             nb_ext;
    logic [6:0]             ptr_sum;
    logic [LEN_BITS-1:0]    bitlen;
    logic [BLOCK_BITS-1:0]  block;
    logic [BLOCK_BITS-1:0]  pad_block;
    logic [BLOCK_BITS-1:0]  len_block;
    logic                   first_pending;
    logic                   msg_open;
    logic                   be_q;
    logic                   be_eff;
    logic [63:0]            lane_en;
    logic [511:0]           lane_data;
    logic                   blk_valid_q;
    logic                   blk_first_q;
    logic                   blk_final_q;

    // Endianness of the opening beat comes straight from the port; later
    // beats use the value latched with it.
    assign be_eff  = msg_open ? be_q : bus.big_endian;
    assign nb_ext  = 7'(bus.in_nbytes);
    assign n       = !bus.in_last ? 7'(IN_BYTES)
                   : (nb_ext > 7'(IN_BYTES) ? 7'(IN_BYTES) : nb_ext);
    assign ptr_sum = ptr + n;

    md_lane_insert #(.IN_BYTES(IN_BYTES)) u_lane_insert (
        .ptr        (ptr),
        .n          (n),
        .beat       (bus.in_data),
        .big_endian (be_eff),
        .en         (lane_en),
        .lanes      (lane_data)
    );

    always_comb begin
        len_block = '0;
        if (be_q) len_block[LEN_BITS-1:0]           = bitlen;
        else      len_block[BLOCK_BITS-1 -: LEN_BITS] = bitlen;

        pad_block = block;
        for (int unsigned j = 0; j < BLOCK_BYTES; j++) begin
            if (7'(j) == ptr)
                pad_block[byte_offset(6'(j), be_q) +: 8] = PAD_BYTE;
            else if (7'(j) > ptr)
                pad_block[byte_offset(6'(j), be_q) +: 8] = '0;
        end
        if (ptr < 7'(LEN_OFFSET)) begin
            if (be_q) pad_block[LEN_BITS-1:0]           = bitlen;
            else      pad_block[BLOCK_BITS-1 -: LEN_BITS] = bitlen;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= FILL;
            after_emit    <= FILL;
            ptr           <= '0;
            bitlen        <= '0;
            block         <= '0;
            first_pending <= 1'b1;
            msg_open      <= 1'b0;
            be_q          <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b0;
            blk_final_q   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        for (int unsigned l = 0; l < BLOCK_BYTES; l++) begin
                            if (lane_en[6'(l)])
                                block[9'(8 * l) +: 8] <= lane_data[9'(8 * l) +: 8];
                        end
                        ptr    <= ptr_sum;
                        bitlen <= bitlen + (LEN_BITS'(n) << 3);
                        if (!msg_open) begin
                            be_q     <= bus.big_endian;
                            msg_open <= 1'b1;
                        end
                        // A last beat that fills the block emits it as plain
                        // data first; padding then starts a fresh block.
                        if (ptr_sum == 7'(BLOCK_BYTES)) begin
                            state       <= EMIT;
                            after_emit  <= bus.in_last ? PAD : FILL;
                            blk_valid_q <= 1'b1;
                            blk_first_q <= first_pending;
                            blk_final_q <= 1'b0;
                        end else if (bus.in_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    block       <= pad_block;
                    state       <= EMIT;
                    after_emit  <= (ptr < 7'(LEN_OFFSET)) ? FILL : EXTRA;
                    blk_valid_q <= 1'b1;
                    blk_first_q <= first_pending;
                    blk_final_q <= (ptr < 7'(LEN_OFFSET));
                end
                EXTRA: begin
                    block       <= len_block;
                    state       <= EMIT;
                    after_emit  <= FILL;
                    blk_valid_q <= 1'b1;
                    blk_first_q <= first_pending;
                    blk_final_q <= 1'b1;
                end
                EMIT: begin
                    if (bus.blk_ready) begin
                        blk_valid_q   <= 1'b0;
                        blk_first_q   <= 1'b0;
                        blk_final_q   <= 1'b0;
                        first_pending <= 1'b0;
                        block         <= '0;
                        ptr           <= '0;
                        if (blk_final_q) begin
                            bitlen        <= '0;
                            first_pending <= 1'b1;
                            msg_open      <= 1'b0;
                            state         <= FILL;
                        end else begin
                            state <= after_emit;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_data  = block;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_final = blk_final_q;
    assign busy          = !(state == FILL && ptr == '0 && !msg_open);

endmodule

// File: tb/tb_md_block_padder.sv
// Directed-vector bench: one padder with 1-byte beats, one with 4-byte beats.
module tb_md_block_padder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy1;
    logic busy4;

    always #5 clk = ~clk;

    md_block_padder_if #(.IN_BYTES(1)) b1();
    md_block_padder_if #(.IN_BYTES(4)) b4();

    md_block_padder #(.IN_BYTES(1), .LEN_BITS(64)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .busy  (busy1),
        .bus   (b1.slave)
    );

    md_block_padder #(.IN_BYTES(4), .LEN_BITS(64)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .busy  (busy4),
        .bus   (b4.slave)
    );

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         fin;
    } blk_t;

    blk_t        q1[$];
    blk_t        q4[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepted blocks are recorded just after the falling edge that
    // precedes their accepting rising edge.
    always @(negedge clk) begin
        #1;
        if (b1.blk_valid && b1.blk_ready) q1.push_back('{b1.blk_data, b1.blk_first, b1.blk_final});
        if (b4.blk_valid && b4.blk_ready) q4.push_back('{b4.blk_data, b4.blk_first, b4.blk_final});
    end

    task automatic send1(input logic [7:0] d, input logic last, input logic nb);
        int unsigned t = 0;
        b1.in_valid = 1'b1; b1.in_data = d; b1.in_last = last; b1.in_nbytes = nb;
        while (!b1.in_ready && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) check("in1_timeout", 512'(t), 512'(0));
        @(negedge clk);
        b1.in_valid = 1'b0; b1.in_last = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int unsigned t = 0;
        b4.in_valid = 1'b1; b4.in_data = d; b4.in_last = last; b4.in_nbytes = nb;
        while (!b4.in_ready && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) check("in4_timeout", 512'(t), 512'(0));
        @(negedge clk);
        b4.in_valid = 1'b0; b4.in_last = 1'b0;
    endtask

    task automatic get1(input string tag, output blk_t b);
        int unsigned t = 0;
        while (q1.size() == 0 && t < 400) begin @(negedge clk); t++; end
        if (q1.size() == 0) begin
            check({tag, "_timeout"}, 512'(0), 512'(1));
            b = '{'0, 1'b0, 1'b0};
        end else b = q1.pop_front();
    endtask

    task automatic get4(input string tag, output blk_t b);
        int unsigned t = 0;
        while (q4.size() == 0 && t < 400) begin @(negedge clk); t++; end
        if (q4.size() == 0) begin
            check({tag, "_timeout"}, 512'(0), 512'(1));
            b = '{'0, 1'b0, 1'b0};
        end else b = q4.pop_front();
    endtask

    task automatic check_blk(input string tag, input blk_t b, input logic [511:0] exp,
                             input logic first, input logic fin);
        check({tag, "_data"},  b.data,  exp);
        check({tag, "_first"}, 512'(b.first), 512'(first));
        check({tag, "_final"}, 512'(b.fin),   512'(fin));
    endtask

    task automatic run_abc(input string tag);
        blk_t         b;
        logic [511:0] exp;
        b1.big_endian = 1'b0;
        send1(8'h61, 1'b0, 1'b0);
        check({tag, "_busy"}, 512'(busy1), 512'(1));
        send1(8'h62, 1'b0, 1'b0);
        send1(8'h63, 1'b1, 1'b1);
        check({tag, "_lat_pad"}, 512'(b1.blk_valid), 512'(0));
        @(negedge clk);
        check({tag, "_lat_emit"}, 512'(b1.blk_valid), 512'(1));
        get1(tag, b);
        exp = '0;
        exp[31:0]    = 32'h80636261;
        exp[511:448] = 64'h18;
        check_blk(tag, b, exp, 1'b1, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        blk_t         b;
        logic [511:0] exp;

        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.in_nbytes = '0;
        b1.big_endian = 1'b0; b1.blk_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0; b4.in_nbytes = '0;
        b4.big_endian = 1'b0; b4.blk_ready = 1'b1;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid", 512'(b1.blk_valid), 512'(0));
        check("rst_first", 512'(b1.blk_first), 512'(0));
        check("rst_final", 512'(b1.blk_final), 512'(0));
        check("rst_busy1", 512'(busy1),        512'(0));
        check("rst_busy4", 512'(busy4),        512'(0));
        check("rst_ready", 512'(b1.in_ready),  512'(1));

        // MD5 "abc", byte-wide beats
        run_abc("abc");

        // SHA "abc" in a single 4-byte beat
        b4.big_endian = 1'b1;
        send4(32'h00636261, 1'b1, 3'd3);
        get4("sha_abc", b);
        exp = '0;
        exp[511:480] = 32'h61626380;
        exp[63:0]    = 64'h18;
        check_blk("sha_abc", b, exp, 1'b1, 1'b1);

        // SHA "abcdef"; endianness flip after the first beat must be ignored
        b4.big_endian = 1'b1;
        send4(32'h64636261, 1'b0, 3'd0);
        b4.big_endian = 1'b0;
        send4(32'h00006665, 1'b1, 3'd2);
        get4("sha_latch", b);
        exp = '0;
        exp[511:448] = 64'h6162636465668000;
        exp[63:0]    = 64'h30;
        check_blk("sha_latch", b, exp, 1'b1, 1'b1);

        // MD5, last beat claims 7 bytes: clamped to 4
        b4.big_endian = 1'b0;
        send4(32'h44332211, 1'b1, 3'd7);
        get4("clamp", b);
        exp = '0;
        exp[39:0]    = 40'h8044332211;
        exp[511:448] = 64'h20;
        check_blk("clamp", b, exp, 1'b1, 1'b1);

        // MD5, 56 bytes: padding spills into an extra length block
        b1.big_endian = 1'b0;
        for (int i = 0; i < 56; i++) send1(8'h41, (i == 55), 1'b1);
        get1("b56_1", b);
        exp = '0;
        for (int i = 0; i < 56; i++) exp[8*i +: 8] = 8'h41;
        exp[455:448] = 8'h80;
        check_blk("b56_1", b, exp, 1'b1, 1'b0);
        get1("b56_2", b);
        exp = '0;
        exp[511:448] = 64'h1C0;
        check_blk("b56_2", b, exp, 1'b0, 1'b1);

        // MD5, 64 bytes ending on a full beat
        for (int i = 0; i < 64; i++) send1(8'(i), (i == 63), 1'b1);
        get1("b64_1", b);
        exp = '0;
        for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(i);
        check_blk("b64_1", b, exp, 1'b1, 1'b0);
        get1("b64_2", b);
        exp = '0;
        exp[7:0]     = 8'h80;
        exp[511:448] = 64'h200;
        check_blk("b64_2", b, exp, 1'b0, 1'b1);

        // Zero-length message held under backpressure
        b1.blk_ready = 1'b0;
        send1(8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        exp = '0;
        exp[7:0] = 8'h80;
        for (int i = 0; i < 10; i++) begin
            check("zl_hold_data",  b1.blk_data,          exp);
            check("zl_hold_ready", 512'(b1.in_ready),    512'(0));
            @(negedge clk);
        end
        check("zl_hold_valid", 512'(b1.blk_valid), 512'(1));
        check("zl_hold_first", 512'(b1.blk_first), 512'(1));
        check("zl_hold_final", 512'(b1.blk_final), 512'(1));
        b1.blk_ready = 1'b1;
        get1("zl", b);
        check_blk("zl", b, exp, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("zl_no_extra", 512'(q1.size()),     512'(0));
        check("zl_idle",     512'(b1.blk_valid),  512'(0));
        check("zl_busy",     512'(busy1),         512'(0));

        // Reset mid-message, then "abc" again
        for (int i = 0; i < 30; i++) send1(8'h55, 1'b0, 1'b0);
        check("mid_busy", 512'(busy1), 512'(1));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",  512'(busy1),       512'(0));
        check("mid_rst_ready", 512'(b1.in_ready), 512'(1));
        run_abc("abc_after_rst");
        repeat (5) @(negedge clk);
        check("final_q1_empty", 512'(q1.size()), 512'(0));
        check("final_q4_empty", 512'(q4.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
